traffic_sensor_conditioner: RTL and testbench
=============================================

Name: traffic_sensor_conditioner

Overview:
Upstream front end of adaptive_traffic_light_controller. It takes raw, noisy vehicle-loop detector inputs (an entry loop and an exit loop per approach), then synchronizes and debounces them. It keeps a saturating queue count per approach and produces the clean per-direction car-present (S1_*) and congestion (S5_*) flags that the controller consumes. It also flags stuck entry detectors and forces those directions into a fail-safe "cars present" state.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronized samples required to change a debounced level (>=2)
CNT_W, 4, queue counter width; QMAX = 2^CNT_W-1
CONG_ON, 5, queue count at or above which S5 asserts
CONG_OFF, 3, queue count at or below which S5 deasserts (must be < CONG_ON)
STUCK_CYCLES, 1024, cycles an entry loop may stay debounced-high before it is declared faulty

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
det_in_NS/SN/EW/WE  in  1 each  raw entry-loop detector, asynchronous to clk
det_out_NS/SN/EW/WE  in  1 each  raw exit-loop detector, asynchronous to clk
S1_NS/SN/EW/WE  out  1 each  cars present on that approach
S5_NS/SN/EW/WE  out  1 each  congestion on that approach
q_NS/SN/EW/WE  out  CNT_W each  current queue count (debug/observability)
fault  out  4  stuck-entry-loop flags {WE,EW,SN,NS}

Behaviour:
- The four approaches are independent and identical. Everything below applies per approach.
- Reset (rst=0, asynchronous): sync flops, debounced levels, debounce counters, queue count, stuck counter, S5 register and fault all clear to 0. Therefore S1=S5=0 and q=0. Reset release takes effect on the next clk edge.
- Synchronizer: each raw input goes through a 2-flop synchronizer. The synchronized value is sync.
- Debounce: the deb counter increments while sync != deb and resets to 0 on any cycle where sync == deb.
  - When the counter would reach DEB_CYCLES, deb toggles and the counter clears.
  - Glitches shorter than DEB_CYCLES cycles never reach deb.
- Events: arr = rising edge of debounced entry loop; dep = rising edge of debounced exit loop. Each is a single-cycle, registered edge detect.
- Queue count update, in priority order each cycle:
  - arr & dep: no change.
  - arr only: +1, saturating at QMAX.
  - dep only: -1, saturating at 0; a departure at 0 is ignored.
- Latency: raw held high from before edge 0 → sync high after edge 2 → deb high after edge 1+DEB_CYCLES+1 → q incremented after the following edge. Total: q changes DEB_CYCLES+3 edges after raw becomes stable.
- S1 = (q != 0) | fault, combinational from registers.
- S5 hysteresis register, updated on the same edge as q using q_next:
  - set when q_next >= CONG_ON;
  - cleared when q_next <= CONG_OFF;
  - held otherwise.
  - S5 is therefore never 1 while q=0.
- Stuck detection:
  - The stuck counter increments while the debounced entry level is 1 and clears when it is 0.
  - At STUCK_CYCLES the fault bit sets and stays set; the counter stops.
  - Fault clears only after the debounced entry level returns to 0 for DEB_CYCLES consecutive cycles (already implied by deb falling). The fault bit clears on the edge deb falls.
  - While fault=1, arrivals are still counted and S1 is forced to 1.
- Reset mid-operation: all state is lost immediately and there is no residual output. After release, inputs that are already high must re-debounce before they generate an arrival.

Decomposition:
- Shared package/header: CNT_W-derived QMAX, and default values for DEB_CYCLES, CONG_ON, CONG_OFF, STUCK_CYCLES, shared with the controller's testbench.
- Sub-module tsc_lane (one approach: 2 synchronizers, 2 debouncers, edge detects, queue counter, hysteresis, stuck detector), instantiated 4×. The top level is wiring only.
- A generic tsc_debounce may be factored out of tsc_lane if desired.

Test Plan:
- Reset/idle: assert rst low mid-run with q_NS=6 → all S1/S5/q/fault are 0 asynchronously. Hold all detectors low for 50 cycles after release → outputs stay 0.
- Debounce: det_in_NS pulses high for 3 cycles → q_NS stays 0. Holding it high for 4+ cycles → q_NS=1 and S1_NS=1 exactly DEB_CYCLES+3=7 edges after the input goes high.
- Congestion hysteresis, SN: 5 clean arrivals → q_SN=5 and S5_SN=1 on the same edge. 1 departure → q=4, S5=1. 1 more → q=3, S5=0. 1 arrival → q=4, S5 still 0.
- Saturation/boundaries, EW: 17 arrivals → q_EW=15. Departures at q=0 → q stays 0, S1_EW=0. Simultaneous debounced arrival and departure edges → q unchanged.
- Stuck loop, WE: det_in_WE held high for 1100 cycles → q_WE=1 and fault[3]=1 at STUCK_CYCLES. 2 departures → q=0 but S1_WE stays 1. Release input → fault[3] clears when deb falls, then S1_WE=0.
- Independence: interleave NS and EW traffic → each q/S1/S5 tracks only its own detectors, with no cross-coupling.

Source files
------------

// File: rtl/traffic_sensor_conditioner_pkg.sv
// rtl/traffic_sensor_conditioner_pkg.sv - shared defaults and helpers for the traffic sensor conditioner
package traffic_sensor_conditioner_pkg;

    localparam int DEB_CYCLES_DEF   = 4;
    localparam int CNT_W_DEF        = 4;
    localparam int CONG_ON_DEF      = 5;
    localparam int CONG_OFF_DEF     = 3;
    localparam int STUCK_CYCLES_DEF = 1024;

    typedef enum logic [1:0] {
        DIR_NS = 2'd0,
        DIR_SN = 2'd1,
        DIR_EW = 2'd2,
        DIR_WE = 2'd3
    } dir_e;

    function automatic int qmax(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// rtl/traffic_sensor_conditioner_if.sv - detector inputs and conditioned flags for all four approaches
interface traffic_sensor_conditioner_if #(
    parameter int CNT_W = 4
);
    logic             det_in_NS, det_in_SN, det_in_EW, det_in_WE;
    logic             det_out_NS, det_out_SN, det_out_EW, det_out_WE;
    logic             S1_NS, S1_SN, S1_EW, S1_WE;
    logic             S5_NS, S5_SN, S5_EW, S5_WE;
    logic [CNT_W-1:0] q_NS, q_SN, q_EW, q_WE;
    logic [3:0]       fault;

    modport master (
        output det_in_NS, det_in_SN, det_in_EW, det_in_WE,
        output det_out_NS, det_out_SN, det_out_EW, det_out_WE,
        input  S1_NS, S1_SN, S1_EW, S1_WE,
        input  S5_NS, S5_SN, S5_EW, S5_WE,
        input  q_NS, q_SN, q_EW, q_WE,
        input  fault
    );

    modport slave (
        input  det_in_NS, det_in_SN, det_in_EW, det_in_WE,
        input  det_out_NS, det_out_SN, det_out_EW, det_out_WE,
        output S1_NS, S1_SN, S1_EW, S1_WE,
        output S5_NS, S5_SN, S5_EW, S5_WE,
        output q_NS, q_SN, q_EW, q_WE,
        output fault
    );
endinterface

// File: rtl/traffic_sensor_conditioner_lane.sv
// rtl/traffic_sensor_conditioner_lane.sv - one approach: sync, debounce, queue count, congestion and stuck detect
module tsc_lane
    import traffic_sensor_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int CONG_ON      = CONG_ON_DEF,
    parameter int CONG_OFF     = CONG_OFF_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det_in,
    input  logic             det_out,
    output logic             s1,
    output logic             s5,
    output logic [CNT_W-1:0] q,
    output logic             fault
);

    localparam int               DW   = $clog2(DEB_CYCLES + 1);
    localparam int               SW   = $clog2(STUCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] QMAX = CNT_W'(qmax(CNT_W));

    // Bit 0 carries the entry loop, bit 1 the exit loop.
    logic [1:0]         meta, sync, deb, deb_d, deb_nxt;
    logic [1:0][DW-1:0] dcnt, dcnt_nxt;
    logic               arr, dep;
    logic [CNT_W-1:0]   q_next;
    logic [SW-1:0]      stk_cnt;

    always_comb begin
        deb_nxt  = deb;
        dcnt_nxt = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync[i] != deb[i]) begin
                if (dcnt[i] == DW'(DEB_CYCLES - 1)) deb_nxt[i] = ~deb[i];
                else                                dcnt_nxt[i] = dcnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta  <= '0;
            sync  <= '0;
            deb   <= '0;
            deb_d <= '0;
            dcnt  <= '0;
        end else begin
            meta  <= {det_out, det_in};
            sync  <= meta;
            deb   <= deb_nxt;
            deb_d <= deb;
            dcnt  <= dcnt_nxt;
        end
    end

    assign arr = deb[0] & ~deb_d[0];
    assign dep = deb[1] & ~deb_d[1];

    always_comb begin
        q_next = q;
        case ({arr, dep})
            2'b10:   q_next = (q == QMAX) ? q : q + 1'b1;
            2'b01:   q_next = (q == '0)   ? q : q - 1'b1;
            default: q_next = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q  <= '0;
            s5 <= 1'b0;
        end else begin
            q <= q_next;
            if (q_next >= CNT_W'(CONG_ON))       s5 <= 1'b1;
            else if (q_next <= CNT_W'(CONG_OFF)) s5 <= 1'b0;
        end
    end

    // Fault drops on the very edge the debounced entry level falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk_cnt <= '0;
            fault   <= 1'b0;
        end else if (!deb[0] || !deb_nxt[0]) begin
            stk_cnt <= '0;
            fault   <= 1'b0;
        end else if (!fault) begin
            if (stk_cnt == SW'(STUCK_CYCLES - 1)) fault   <= 1'b1;
            else                                  stk_cnt <= stk_cnt + 1'b1;
        end
    end

    assign s1 = (q != '0) | fault;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// rtl/traffic_sensor_conditioner.sv - four independent approach lanes feeding the traffic light controller
module traffic_sensor_conditioner
    import traffic_sensor_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int CONG_ON      = CONG_ON_DEF,
    parameter int CONG_OFF     = CONG_OFF_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    traffic_sensor_conditioner_if.slave bus
);

    tsc_lane #(
        .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W), .CONG_ON(CONG_ON),
        .CONG_OFF(CONG_OFF), .STUCK_CYCLES(STUCK_CYCLES)
    ) u_ns (
        .clk(clk), .rst(rst), .det_in(bus.det_in_NS), .det_out(bus.det_out_NS),
        .s1(bus.S1_NS), .s5(bus.S5_NS), .q(bus.q_NS), .fault(bus.fault[0])
    );

    tsc_lane #(
        .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W), .CONG_ON(CONG_ON),
        .CONG_OFF(CONG_OFF), .STUCK_CYCLES(STUCK_CYCLES)
    ) u_sn (
        .clk(clk), .rst(rst), .det_in(bus.det_in_SN), .det_out(bus.det_out_SN),
        .s1(bus.S1_SN), .s5(bus.S5_SN), .q(bus.q_SN), .fault(bus.fault[1])
    );

    tsc_lane #(
        .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W), .CONG_ON(CONG_ON),
        .CONG_OFF(CONG_OFF), .STUCK_CYCLES(STUCK_CYCLES)
    ) u_ew (
        .clk(clk), .rst(rst), .det_in(bus.det_in_EW), .det_out(bus.det_out_EW),
        .s1(bus.S1_EW), .s5(bus.S5_EW), .q(bus.q_EW), .fault(bus.fault[2])
    );

    tsc_lane #(
        .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W), .CONG_ON(CONG_ON),
        .CONG_OFF(CONG_OFF), .STUCK_CYCLES(STUCK_CYCLES)
    ) u_we (
        .clk(clk), .rst(rst), .det_in(bus.det_in_WE), .det_out(bus.det_out_WE),
        .s1(bus.S1_WE), .s5(bus.S5_WE), .q(bus.q_WE), .fault(bus.fault[3])
    );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb/tb_traffic_sensor_conditioner.sv - directed scoreboard bench for traffic_sensor_conditioner
module tb_traffic_sensor_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = '0;
    logic [3:0] dout = '0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        int         lane;
        logic [3:0] q;
        logic       s1;
        logic       s5;
        logic       f;
    } exp_t;

    exp_t sb[$];
    int   mq[4];
    bit   ms5[4];
    bit   mf[4];

    always #5 clk = ~clk;

    traffic_sensor_conditioner_if #(.CNT_W(4)) bus ();

    assign bus.det_in_NS  = din[0];
    assign bus.det_in_SN  = din[1];
    assign bus.det_in_EW  = din[2];
    assign bus.det_in_WE  = din[3];
    assign bus.det_out_NS = dout[0];
    assign bus.det_out_SN = dout[1];
    assign bus.det_out_EW = dout[2];
    assign bus.det_out_WE = dout[3];

    traffic_sensor_conditioner dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    function automatic logic [6:0] observe(input int l);
        case (l)
            0:       return {bus.q_NS, bus.S1_NS, bus.S5_NS, bus.fault[0]};
            1:       return {bus.q_SN, bus.S1_SN, bus.S5_SN, bus.fault[1]};
            2:       return {bus.q_EW, bus.S1_EW, bus.S5_EW, bus.fault[2]};
            default: return {bus.q_WE, bus.S1_WE, bus.S5_WE, bus.fault[3]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int l);
        exp_t e;
        if (mq[l] >= 5)      ms5[l] = 1'b1;
        else if (mq[l] <= 3) ms5[l] = 1'b0;
        e.tag  = tag;
        e.lane = l;
        e.q    = 4'(mq[l]);
        e.s1   = (mq[l] != 0) || mf[l];
        e.s5   = ms5[l];
        e.f    = mf[l];
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [6:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.lane);
            check($sformatf("%s.l%0d.q", e.tag, e.lane),  32'(o[6:3]), 32'(e.q));
            check($sformatf("%s.l%0d.s1", e.tag, e.lane), 32'(o[2]),   32'(e.s1));
            check($sformatf("%s.l%0d.s5", e.tag, e.lane), 32'(o[1]),   32'(e.s5));
            check($sformatf("%s.l%0d.f", e.tag, e.lane),  32'(o[0]),   32'(e.f));
        end
    endtask

    task automatic pulse(input int l, input bit is_exit, input int hi);
        @(negedge clk);
        if (is_exit) dout[l] = 1'b1; else din[l] = 1'b1;
        repeat (hi) @(negedge clk);
        if (is_exit) dout[l] = 1'b0; else din[l] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic arrive(input int l);
        pulse(l, 1'b0, 6);
        if (mq[l] < 15) mq[l]++;
        push_exp("arr", l);
        drain();
    endtask

    task automatic depart(input int l);
        pulse(l, 1'b1, 6);
        if (mq[l] > 0) mq[l]--;
        push_exp("dep", l);
        drain();
    endtask

    task automatic expect_all(input string tag);
        for (int l = 0; l < 4; l++) push_exp(tag, l);
        drain();
    endtask

    initial begin
        for (int l = 0; l < 4; l++) begin mq[l] = 0; ms5[l] = 0; mf[l] = 0; end

        repeat (3) @(negedge clk);
        expect_all("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        expect_all("idle");

        // Three-cycle glitch must never reach the debounced level.
        pulse(0, 1'b0, 3);
        push_exp("glitch", 0);
        drain();

        // Arrival latency: q moves on the 7th rising edge after the raw rise.
        @(negedge clk);
        din[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("lat.q_before", 32'(bus.q_NS), 32'd0);
        @(posedge clk);
        #1 check("lat.q_at", 32'(bus.q_NS), 32'd1);
        check("lat.s1_at", 32'(bus.S1_NS), 32'd1);
        @(negedge clk);
        din[0] = 1'b0;
        repeat (12) @(negedge clk);
        mq[0] = 1;

        for (int i = 0; i < 5; i++) arrive(0);

        // Asynchronous reset in the middle of a clock phase with q_NS=6.
        #2 rst_n = 1'b0;
        #1;
        for (int l = 0; l < 4; l++) mq[l] = 0;
        expect_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        expect_all("post_rst");

        // Congestion hysteresis on SN.
        for (int i = 0; i < 5; i++) arrive(1);
        depart(1);
        depart(1);
        arrive(1);

        // Saturation and floor on EW.
        for (int i = 0; i < 17; i++) arrive(2);
        for (int i = 0; i < 16; i++) depart(2);
        arrive(2);
        @(negedge clk);
        din[2]  = 1'b1;
        dout[2] = 1'b1;
        repeat (6) @(negedge clk);
        din[2]  = 1'b0;
        dout[2] = 1'b0;
        repeat (12) @(negedge clk);
        push_exp("simul", 2);
        drain();

        // Stuck entry loop on WE.
        @(negedge clk);
        din[3] = 1'b1;
        repeat (1029) @(posedge clk);
        #1 check("stuck.f_before", 32'(bus.fault[3]), 32'd0);
        @(posedge clk);
        #1 check("stuck.f_at", 32'(bus.fault[3]), 32'd1);
        repeat (70) @(negedge clk);
        mq[3] = 1;
        mf[3] = 1'b1;
        push_exp("stuck", 3);
        drain();
        depart(3);
        depart(3);
        @(negedge clk);
        din[3] = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("stuck.f_hold", 32'(bus.fault[3]), 32'd1);
        @(posedge clk);
        #1 check("stuck.f_clr", 32'(bus.fault[3]), 32'd0);
        check("stuck.s1_clr", 32'(bus.S1_WE), 32'd0);
        repeat (12) @(negedge clk);
        mf[3] = 1'b0;
        push_exp("unstuck", 3);
        drain();

        // Independence: NS arrival overlapping an EW departure.
        @(negedge clk);
        din[0]  = 1'b1;
        dout[2] = 1'b1;
        repeat (6) @(negedge clk);
        din[0]  = 1'b0;
        dout[2] = 1'b0;
        repeat (12) @(negedge clk);
        mq[0] = 1;
        mq[2] = 0;
        expect_all("indep");
        arrive(2);
        expect_all("indep2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
